// File: rtl/if_stage.sv
// Instruction fetch stage feeding decode.
// Holds the fetch PC. Issues one outstanding request at a time to instruction
// memory over a valid/ready request channel and a valid-only response channel.
// Returned instructions go into a 2-entry FIFO, and the FIFO head drives decode.
// Redirects flush the FIFO and drop any stale in-flight response.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   stallD                    decode stalled, head entry held
//   redirectValid/redirectPc  taken branch/jump from EXE
//   imemReq*                  request channel to instruction memory
//   imemResp*                 response channel from instruction memory
//   validD/pcD/instD          registered head-of-FIFO outputs to decode
module if_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallD,
    input  logic        redirectValid,
    input  logic [63:0] redirectPc,
    output logic        imemReqValid,
    input  logic        imemReqReady,
    output logic [63:0] imemReqAddr,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    output logic        validD,
    output logic [63:0] pcD,
    output logic [31:0] instD
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam int unsigned CW   = 2;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_fetch_pc;
    logic              r_drop;
    logic [CW-1:0]     r_count;
    logic              r_valid;
    logic [XLEN-1:0]   r_pc0, r_pc1;
    logic [ILEN-1:0]   r_inst0, r_inst1;

    logic              w_accept;
    logic              w_resp;
    logic              w_pop;
    logic              w_push;
    logic [XLEN-1:0]   w_redirect_pc;
    logic [CW-1:0]     w_count_nxt;
    logic [XLEN-1:0]   w_pc0_nxt, w_pc1_nxt;
    logic [ILEN-1:0]   w_inst0_nxt, w_inst1_nxt;
    logic              w_drop_nxt;
    logic [XLEN-1:0]   w_fetch_pc_nxt;

    assign w_redirect_pc = redirectPc & ~XLEN'(3);
    assign w_accept      = imemReqValid & imemReqReady;
    assign w_resp        = (r_state == S_WAIT) & imemRespValid;
    assign w_pop         = (r_count != '0) & ~stallD & ~redirectValid;
    // Count never exceeds 2; a push at count 2 is only legal alongside a pop
    assign w_push        = w_resp & ~r_drop & ~redirectValid
                           & ((r_count != CW'(2)) | w_pop);

    // FIFO next-state; entry 0 reads as 0/NOP_INST whenever the FIFO is empty
    always_comb begin
        w_count_nxt = r_count;
        w_pc0_nxt   = r_pc0;
        w_pc1_nxt   = r_pc1;
        w_inst0_nxt = r_inst0;
        w_inst1_nxt = r_inst1;
        if (redirectValid) begin
            w_count_nxt = '0;
            w_pc0_nxt   = '0;
            w_inst0_nxt = NOP_INST;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_count == CW'(2)) begin
                        w_pc0_nxt   = r_pc1;
                        w_inst0_nxt = r_inst1;
                        w_pc1_nxt   = r_fetch_pc;
                        w_inst1_nxt = imemRespData;
                    end else begin
                        w_pc0_nxt   = r_fetch_pc;
                        w_inst0_nxt = imemRespData;
                    end
                end
                2'b01: begin
                    w_count_nxt = r_count - CW'(1);
                    if (r_count == CW'(2)) begin
                        w_pc0_nxt   = r_pc1;
                        w_inst0_nxt = r_inst1;
                    end else begin
                        w_pc0_nxt   = '0;
                        w_inst0_nxt = NOP_INST;
                    end
                end
                2'b10: begin
                    w_count_nxt = r_count + CW'(1);
                    if (r_count == '0) begin
                        w_pc0_nxt   = r_fetch_pc;
                        w_inst0_nxt = imemRespData;
                    end else begin
                        w_pc1_nxt   = r_fetch_pc;
                        w_inst1_nxt = imemRespData;
                    end
                end
                default: ;
            endcase
        end
    end

    // Fetch PC and the drop flag for a stale outstanding response
    always_comb begin
        w_fetch_pc_nxt = r_fetch_pc;
        w_drop_nxt     = r_drop;
        if (redirectValid) begin
            w_fetch_pc_nxt = w_redirect_pc;
            if (r_state == S_WAIT) begin
                w_drop_nxt = ~imemRespValid;
            end else begin
                w_drop_nxt = w_accept;
            end
        end else begin
            if (w_push) begin
                w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
            end
            if (w_resp) begin
                w_drop_nxt = 1'b0;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ: begin
                if (w_accept) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imemRespValid) begin
                    if (redirectValid || (w_count_nxt < CW'(2))) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirectValid || w_pop) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    // Request outputs; held low while reset is asserted
    always_comb begin
        imemReqValid = (r_state == S_REQ) && !rst;
        imemReqAddr  = r_fetch_pc;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_drop     <= 1'b0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_pc0      <= '0;
            r_pc1      <= '0;
            r_inst0    <= NOP_INST;
            r_inst1    <= NOP_INST;
        end else begin
            r_fetch_pc <= w_fetch_pc_nxt;
            r_drop     <= w_drop_nxt;
            r_count    <= w_count_nxt;
            r_valid    <= (w_count_nxt != '0);
            r_pc0      <= w_pc0_nxt;
            r_pc1      <= w_pc1_nxt;
            r_inst0    <= w_inst0_nxt;
            r_inst1    <= w_inst1_nxt;
        end
    end

    assign validD = r_valid;
    assign pcD    = r_pc0;
    assign instD  = r_inst0;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage: the producer of the decode stage's pcD/instD inputs.
- Holds the fetch PC and issues single-outstanding requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions in a 2-entry FIFO whose head drives decode.
- Honours stallD from the hazard unit and branch/jump redirects from EXE, discarding stale in-flight responses.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, instruction presented on instD when no valid entry (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
stallD  in  1  decode stalled; head entry is held
redirectValid  in  1  branch/jump taken in EXE; flush and refetch
redirectPc  in  64  new fetch address; bits [1:0] are forced to 0
imemReqValid  out  1  request to instruction memory
imemReqReady  in  1  memory accepts request
imemReqAddr  out  64  request address
imemRespValid  in  1  response data valid, arrives 1 or more cycles after acceptance
imemRespData  in  32  instruction word
validD  out  1  pcD/instD hold a real instruction
pcD  out  64  PC of head instruction
instD  out  32  head instruction, NOP_INST when validD=0

Behaviour:
- Reset (async, rst=1):
  - fetchPc=RESET_PC, state=S_REQ, FIFO count=0, drop=0.
  - Outputs: imemReqValid=0 while rst=1, validD=0, pcD=0, instD=NOP_INST.
- Outputs are registered: validD=(count!=0); pcD/instD = FIFO entry 0, or 0/NOP_INST when empty. A response accepted in cycle N is visible on validD in cycle N+1 if the FIFO was empty.
- Pop: validD & ~stallD & ~redirectValid; entry1 shifts to entry0.
- Push: accepted response with drop=0 and no redirect that cycle. It writes {fetchPc, imemRespData} at the tail, then fetchPc <= fetchPc+4 (64-bit wrap).
- Push and pop in the same cycle are legal; count is unchanged and the new entry lands correctly.
- State machine, one request outstanding at most:
  - S_REQ:
    - imemReqValid=1, imemReqAddr=fetchPc.
    - Address is stable while valid & ~ready, except on redirect, which retargets it the next cycle.
    - On valid & ready -> S_WAIT.
  - S_WAIT:
    - imemReqValid=0.
    - On imemRespValid: if drop=1 or redirectValid, discard the data and clear drop.
    - Otherwise push.
    - Next state is S_REQ if count after push/pop < 2, else S_HOLD.
  - S_HOLD: FIFO full, imemReqValid=0; -> S_REQ when a pop occurs.
- Redirect (redirectValid=1), which takes priority over stallD, pop, and push:
  - FIFO cleared (count=0, validD=0 next cycle), fetchPc <= {redirectPc[63:2],2'b00}.
  - S_WAIT without a response this cycle: drop <= 1 and stay in S_WAIT.
  - S_WAIT with a response this cycle: data discarded, -> S_REQ.
  - S_HOLD or S_REQ: -> S_REQ with the new address.
  - If the request handshake completes in the same cycle as the redirect, that request is still outstanding: drop <= 1, -> S_WAIT.
- imemRespValid in S_REQ or S_HOLD is a protocol error; it is ignored and the FIFO is unchanged.
- rst asserted mid-transaction: immediate return to reset values. Any later response is ignored because state is S_REQ.
- stallD=1 with count=2: no new request is issued. Deassertion resumes fetch the cycle after the pop.

Test Plan:
- Reset release, ready=1, 1-cycle response latency, instructions I0..I3 -> requests to 0x80000000, 0x80000004, …; validD rises with pcD=0x80000000, instD=I0; each subsequent instruction appears in order with pcD incrementing by 4.
- stallD held high for 6 cycles -> FIFO fills to 2, imemReqValid=0 in S_HOLD, pcD/instD constant; release stallD -> entries drain in order, fetch resumes at the next PC.
- Redirect to 0x80000103 while a request is outstanding, response arriving 3 cycles later -> validD=0 next cycle, stale response discarded; next request address is 0x80000100 and pcD shows 0x80000100.
- Redirect in the same cycle as imemRespValid -> response not pushed, validD=0, next request to the redirect PC.
- imemReqReady low for 4 cycles -> imemReqValid stays 1 with a stable address; handshake completes on the first ready cycle.
- rst asserted during S_WAIT with 1 FIFO entry -> validD=0 and instD=0x00000013 immediately; after release, the first request is to 0x80000000.
